nshift_rx: RTL and testbench

- Serial-in, parallel-out receiver. It is the far end of the team's n-bit parallel-load shift serializer.
- Collects n serial bits into a word, shifting left or right per the frame's direction flag.
- Presents the word with a valid/ack handshake.
- Sits between a serial link and a parallel consumer; flags framing and overrun errors.

---
 rtl/nshift_rx_pkg.sv | 14 +
 rtl/nshift_rx_core.sv | 44 ++++
 rtl/nshift_rx.sv | 106 ++++++++++
 tb/tb_nshift_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nshift_rx_pkg.sv
// nshift_rx shared definitions
// state encoding and frame direction constants
package nshift_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/nshift_rx_core.sv
// nshift_rx_core: bidirectional shift register and bit counter
// nxt is the value the register takes on an accepted bit
module nshift_rx_core
    import nshift_rx_pkg::*;
#(
    parameter int n  = 4,
    parameter int CW = $clog2(n)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic         dir,
    input  logic         din,
    output logic [n-1:0] nxt,
    output logic         last
);

    logic [n-1:0]  sr;
    logic [CW-1:0] count;

    // shifted value for the incoming bit
    always_comb begin
        nxt = {sr[n-2:0], din};
        if (dir == DIR_RIGHT)
            nxt = {din, sr[n-1:1]};
    end

    assign last = (count == CW'(n - 1));

    // shift register and counter; counter returns to 0 after the n-th bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr    <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            sr    <= nxt;
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/nshift_rx.sv
// nshift_rx: serial-in parallel-out receiver
// frame FSM with valid/ack handshake and error pulses
module nshift_rx
    import nshift_rx_pkg::*;
#(
    parameter int n  = 4,
    parameter int CW = $clog2(n)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic         en,
    input  logic         din,
    input  logic         ack,
    output logic [n-1:0] Q,
    output logic         valid,
    output logic         busy,
    output logic         framing_err,
    output logic         overrun
);

    state_t       state;
    state_t       state_nxt;
    logic         dir_q;
    logic         clr;
    logic         shf;
    logic         load;
    logic         fe_nxt;
    logic         ov_nxt;
    logic         last;
    logic [n-1:0] word;

    nshift_rx_core #(.n(n), .CW(CW)) u_core (
        .clock (clock),
        .reset (reset),
        .clear (clr),
        .en    (shf),
        .dir   (dir_q),
        .din   (din),
        .nxt   (word),
        .last  (last)
    );

    // next state; restart beats a bit strobe in the same cycle
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shf       = 1'b0;
        load      = 1'b0;
        fe_nxt    = 1'b0;
        ov_nxt    = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                if (start) begin
                    state_nxt = RECV;
                    clr       = 1'b1;
                end
            end
            (state == RECV): begin
                if (start) begin
                    clr    = 1'b1;
                    fe_nxt = 1'b1;
                end else if (en) begin
                    shf = 1'b1;
                    if (last) begin
                        load      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            (state == HOLD): begin
                if (ack) begin
                    state_nxt = start ? RECV : IDLE;
                    clr       = start;
                end else if (en) begin
                    ov_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, latched direction, output word and error pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dir_q       <= DIR_LEFT;
            Q           <= '0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            framing_err <= fe_nxt;
            overrun     <= ov_nxt;
            if (clr)
                dir_q <= dir;
            if (load)
                Q <= word;
        end
    end

    assign busy  = (state == RECV);
    assign valid = (state == HOLD);

endmodule

// File: tb/tb_nshift_rx.sv
// tb_nshift_rx: directed and randomized checks of nshift_rx
// n=4 and n=8 instances share inputs, gated by sel
module tb_nshift_rx;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic dir   = 1'b0;
    logic en    = 1'b0;
    logic din   = 1'b0;
    logic ack   = 1'b0;
    logic sel   = 1'b0;

    logic [3:0] q4;
    logic       v4, b4, fe4, ov4;
    logic [7:0] q8;
    logic       v8, b8, fe8, ov8;

    int compared = 0;
    int mism     = 0;

    always #5 clock = ~clock;

    nshift_rx #(.n(4)) dut4 (
        .clock(clock), .reset(reset),
        .start(start & ~sel), .dir(dir),
        .en(en & ~sel), .din(din),
        .ack(ack & ~sel),
        .Q(q4), .valid(v4), .busy(b4),
        .framing_err(fe4), .overrun(ov4)
    );

    nshift_rx #(.n(8)) dut8 (
        .clock(clock), .reset(reset),
        .start(start & sel), .dir(dir),
        .en(en & sel), .din(din),
        .ack(ack & sel),
        .Q(q8), .valid(v8), .busy(b8),
        .framing_err(fe8), .overrun(ov8)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // expected word from the bit order alone:
    // left frames put bit 0 in the MSB, right frames in the LSB
    function automatic logic [31:0] model(input int w,
                                          input logic d,
                                          input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++)
            if (b[i])
                r = r | (32'd1 << (d ? i : w - 1 - i));
        return r;
    endfunction

    // start a frame, then feed w bits back to back (b[0] first)
    task automatic send(input int w, input logic d,
                        input logic [7:0] b);
        logic vo;
        start = 1'b1;
        dir   = d;
        en    = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < w; i++) begin
            en  = 1'b1;
            din = b[i];
            step();
            vo = sel ? v8 : v4;
            if (i < w - 1)
                chk("send_early_valid", 32'(vo), 32'd0);
        end
        en = 1'b0;
    endtask

    initial begin
        logic       d;
        logic [3:0] bits;
        int         gaps;

        #2;
        chk("rst_q4", 32'(q4), 32'd0);
        chk("rst_flags4", 32'({v4, b4, fe4, ov4}), 32'd0);
        chk("rst_q8", 32'(q8), 32'd0);
        #10 reset = 1'b0;

        // left frame 1,0,1,1
        send(4, 1'b0, 8'b1101);
        chk("t1_q", 32'(q4), 32'hb);
        chk("t1_valid", 32'(v4), 32'd1);
        chk("t1_busy", 32'(b4), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t1_ack_valid", 32'(v4), 32'd0);
        chk("t1_ack_busy", 32'(b4), 32'd0);
        chk("t1_q_kept", 32'(q4), 32'hb);

        // right frame with gaps
        start = 1'b1; dir = 1'b1;
        step();
        start = 1'b0;
        chk("t2_busy", 32'(b4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            en = 1'b0; din = 1'b1;
            step();
            chk("t2_gap_valid", 32'(v4), 32'd0);
            en = 1'b1; din = (i != 1);
            step();
            chk("t2_valid", 32'(v4), (i == 3) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        chk("t2_q", 32'(q4), 32'hd);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // restart mid frame
        start = 1'b1; dir = 1'b0;
        step();
        start = 1'b0; en = 1'b1; din = 1'b1;
        step();
        step();
        chk("t3_fe_before", 32'(fe4), 32'd0);
        start = 1'b1; dir = 1'b1;
        step();
        start = 1'b0;
        chk("t3_fe_pulse", 32'(fe4), 32'd1);
        chk("t3_busy", 32'(b4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            din = (i == 3);
            step();
            chk("t3_fe_low", 32'(fe4), 32'd0);
        end
        en = 1'b0;
        chk("t3_q", 32'(q4), 32'h8);
        chk("t3_valid", 32'(v4), 32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // overrun while waiting for ack
        send(4, 1'b0, 8'b0110);
        chk("t4_q", 32'(q4), 32'h6);
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; din = 1'b1;
            step();
            chk("t4_ov", 32'(ov4), 32'd1);
            chk("t4_q_hold", 32'(q4), 32'h6);
            chk("t4_valid", 32'(v4), 32'd1);
        end
        en = 1'b0; ack = 1'b1; start = 1'b1; dir = 1'b0;
        step();
        ack = 1'b0; start = 1'b0;
        chk("t4_b2b_valid", 32'(v4), 32'd0);
        chk("t4_b2b_busy", 32'(b4), 32'd1);
        chk("t4_ov_low", 32'(ov4), 32'd0);

        // async reset mid frame, then a fresh frame
        en = 1'b1; din = 1'b1;
        step();
        step();
        en = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("t5_rst_q", 32'(q4), 32'd0);
        chk("t5_rst_flags", 32'({v4, b4, fe4, ov4}), 32'd0);
        #2 reset = 1'b0;
        send(4, 1'b0, 8'b1010);
        chk("t5_q", 32'(q4), 32'h5);
        chk("t5_valid", 32'(v4), 32'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // n=8 instance
        sel = 1'b1;
        send(8, 1'b0, 8'h81);
        chk("t6_q", 32'(q8), 32'h81);
        chk("t6_valid", 32'(v8), 32'd1);
        start = 1'b1; dir = 1'b1;
        step();
        start = 1'b0;
        chk("t6_ign_valid", 32'(v8), 32'd1);
        chk("t6_ign_busy", 32'(b8), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t6_ack", 32'(v8), 32'd0);
        sel = 1'b0;
        chk("t6_q4_untouched", 32'(q4), 32'h5);

        // randomized frames on the n=4 instance
        for (int f = 0; f < 20; f++) begin
            d    = 1'($urandom_range(0, 1));
            bits = 4'($urandom_range(0, 15));
            start = 1'b1; dir = d;
            en = 1'($urandom_range(0, 1));
            din = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            chk("rnd_busy", 32'(b4), 32'd1);
            for (int i = 0; i < 4; i++) begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    en = 1'b0;
                    din = 1'($urandom_range(0, 1));
                    step();
                    chk("rnd_gap_valid", 32'(v4), 32'd0);
                end
                en = 1'b1; din = bits[i];
                step();
                chk("rnd_valid", 32'(v4),
                    (i == 3) ? 32'd1 : 32'd0);
            end
            en = 1'b0;
            chk("rnd_q", 32'(q4), model(4, d, 32'(bits)));
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                step();
                chk("rnd_wait_valid", 32'(v4), 32'd1);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("rnd_ack_valid", 32'(v4), 32'd0);
            chk("rnd_q_kept", 32'(q4), model(4, d, 32'(bits)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
